// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the memory-stage access controller
//
// Contents:
//   memState_t              FSM state encoding (IDLE, BUSY, DONE)
//   DEFAULT_TIMEOUT_CYCLES  default access timeout in BUSY cycles
//   DEFAULT_TCNT_W          default timeout counter width
//   MEM_CTRL_W              width of the access size/sign code
package mem_ctrl_pkg;

    localparam int MEM_CTRL_W             = 6;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int DEFAULT_TCNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memState_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - req/ack bus between the access controller and the data memory
//
// Signals:
//   MemReq_OUT      controller -> memory  request, held high for the whole access
//   MemWe_OUT       controller -> memory  1 = write, 0 = read
//   MemControl_OUT  controller -> memory  access size/sign code
//   MemAddr_OUT     controller -> memory  access address
//   MemWData_OUT    controller -> memory  store data
//   MemAck_IN       memory -> controller  completion strobe, read data valid same cycle
//   MemRData_IN     memory -> controller  read data
// Modports: master (controller side), slave (memory side).
interface mem_access_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                  MemReq_OUT;
    logic                  MemWe_OUT;
    logic [MEM_CTRL_W-1:0] MemControl_OUT;
    logic [31:0]           MemAddr_OUT;
    logic [31:0]           MemWData_OUT;
    logic                  MemAck_IN;
    logic [31:0]           MemRData_IN;

    modport master (
        output MemReq_OUT,
        output MemWe_OUT,
        output MemControl_OUT,
        output MemAddr_OUT,
        output MemWData_OUT,
        input  MemAck_IN,
        input  MemRData_IN
    );

    modport slave (
        input  MemReq_OUT,
        input  MemWe_OUT,
        input  MemControl_OUT,
        input  MemAddr_OUT,
        input  MemWData_OUT,
        output MemAck_IN,
        output MemRData_IN
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - counts un-acked BUSY cycles and flags the last allowed one
//
// Ports:
//   CLOCK    in   system clock
//   RESET    in   synchronous active-high reset
//   Clear    in   zero the count (takes priority over Enable)
//   Enable   in   advance the count by one
//   Expired  out  count has reached TIMEOUT_CYCLES-1
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TCNT_W         = 16
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic Clear,
    input  logic Enable,
    output logic Expired
);

    localparam logic [TCNT_W-1:0] LAST_COUNT = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [TCNT_W-1:0] count;

    // Holding at LAST_COUNT keeps the counter from wrapping if Clear is late.
    always_ff @(posedge CLOCK) begin
        if (RESET || Clear) begin
            count <= '0;
        end else if (Enable && !Expired) begin
            count <= count + TCNT_W'(1);
        end
    end

    assign Expired = (count == LAST_COUNT);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage load/store sequencer with pipeline stall and timeout
//
// Optional build macro: MEM_ACCESS_PERF_EN adds AccessCount_OUT and StallCycles_OUT.
//
// Ports:
//   CLOCK, RESET                 clock, synchronous active-high reset
//   MemRead_IN, MemWrite_IN      load / store pending in EXE/MEM (both high = write)
//   MemControl_IN                access size/sign code from EXE/MEM
//   Address_IN, WriteData_IN     ALU result and store data from EXE/MEM
//   memBus                       req/ack bus to the data memory (master side)
//   ReadData_OUT                 captured load data, to MEM/WB
//   STALL_OUT                    stall to IF/ID, ID/EXE and EXE/MEM
//   FLUSH_OUT                    bubble into MEM/WB
//   Timeout_OUT                  one-cycle pulse when an access is abandoned
//   AccessCount_OUT              (perf build) number of accesses started
//   StallCycles_OUT              (perf build) number of cycles with STALL_OUT high
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TCNT_W         = DEFAULT_TCNT_W
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  MemRead_IN,
    input  logic                  MemWrite_IN,
    input  logic [MEM_CTRL_W-1:0] MemControl_IN,
    input  logic [31:0]           Address_IN,
    input  logic [31:0]           WriteData_IN,
    mem_access_ctrl_if.master     memBus,
    output logic [31:0]           ReadData_OUT,
    output logic                  STALL_OUT,
    output logic                  FLUSH_OUT,
    output logic                  Timeout_OUT
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0]           AccessCount_OUT,
    output logic [31:0]           StallCycles_OUT
`endif
);

    memState_t             state;
    memState_t             stateNext;

    logic                  memAccess;
    logic                  latchReq;
    logic                  captureRead;
    logic                  timeoutHit;
    logic                  expired;

    logic                  weReg;
    logic [MEM_CTRL_W-1:0] ctrlReg;
    logic [31:0]           addrReg;
    logic [31:0]           wdataReg;
    logic [31:0]           readDataReg;
    logic                  timeoutReg;

    assign memAccess = MemRead_IN | MemWrite_IN;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TCNT_W         (TCNT_W)
    ) timeoutCounter (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .Clear   (state != BUSY),
        .Enable  ((state == BUSY) && !memBus.MemAck_IN),
        .Expired (expired)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // An ack wins over expiry when both land in the same cycle.
    always_comb begin
        stateNext   = state;
        latchReq    = 1'b0;
        captureRead = 1'b0;
        timeoutHit  = 1'b0;
        case (state)
            IDLE: begin
                if (memAccess) begin
                    latchReq  = 1'b1;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (memBus.MemAck_IN) begin
                    captureRead = !weReg;
                    stateNext   = DONE;
                end else if (expired) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end
            end
            DONE: begin
                // EXE/MEM advances at the end of this cycle, so never reissue.
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            weReg       <= 1'b0;
            ctrlReg     <= '0;
            addrReg     <= '0;
            wdataReg    <= '0;
            readDataReg <= '0;
            timeoutReg  <= 1'b0;
        end else begin
            timeoutReg <= timeoutHit;
            if (latchReq) begin
                weReg    <= MemWrite_IN;
                ctrlReg  <= MemControl_IN;
                addrReg  <= Address_IN;
                wdataReg <= WriteData_IN;
            end
            if (captureRead) begin
                readDataReg <= memBus.MemRData_IN;
            end else if (timeoutHit) begin
                readDataReg <= '0;
            end
        end
    end

    assign memBus.MemReq_OUT     = (state == BUSY);
    assign memBus.MemWe_OUT      = weReg;
    assign memBus.MemControl_OUT = ctrlReg;
    assign memBus.MemAddr_OUT    = addrReg;
    assign memBus.MemWData_OUT   = wdataReg;

    assign ReadData_OUT = readDataReg;
    assign Timeout_OUT  = timeoutReg;
    assign STALL_OUT    = ((state == IDLE) && memAccess) || (state == BUSY);
    assign FLUSH_OUT    = STALL_OUT;

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] accessCount;
    logic [31:0] stallCycles;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            accessCount <= '0;
            stallCycles <= '0;
        end else begin
            if (latchReq) begin
                accessCount <= accessCount + 32'd1;
            end
            if (STALL_OUT) begin
                stallCycles <= stallCycles + 32'd1;
            end
        end
    end

    assign AccessCount_OUT = accessCount;
    assign StallCycles_OUT = stallCycles;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl (TIMEOUT_CYCLES = 8)
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    typedef struct {
        logic [31:0] readData;
        logic        timeout;
        int          stall;
        int          req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  ctrl;
    } exp_t;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        MemRead_IN = 1'b0;
    logic        MemWrite_IN = 1'b0;
    logic [5:0]  MemControl_IN = '0;
    logic [31:0] Address_IN = '0;
    logic [31:0] WriteData_IN = '0;
    logic [31:0] ReadData_OUT;
    logic        STALL_OUT;
    logic        FLUSH_OUT;
    logic        Timeout_OUT;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] AccessCount_OUT;
    logic [31:0] StallCycles_OUT;
`endif

    mem_access_ctrl_if memBus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(8), .TCNT_W(16)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .MemRead_IN    (MemRead_IN),
        .MemWrite_IN   (MemWrite_IN),
        .MemControl_IN (MemControl_IN),
        .Address_IN    (Address_IN),
        .WriteData_IN  (WriteData_IN),
        .memBus        (memBus),
        .ReadData_OUT  (ReadData_OUT),
        .STALL_OUT     (STALL_OUT),
        .FLUSH_OUT     (FLUSH_OUT),
        .Timeout_OUT   (Timeout_OUT)
`ifdef MEM_ACCESS_PERF_EN
        ,
        .AccessCount_OUT (AccessCount_OUT),
        .StallCycles_OUT (StallCycles_OUT)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    int   nCompared = 0;
    int   nMismatched = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: acks in BUSY cycle ackDelay (0 = never), or when forced.
    int          ackDelay = 0;
    logic [31:0] rdataVal = '0;
    logic        forceAck = 1'b0;
    int          busyCnt = 0;

    initial begin
        memBus.MemAck_IN   = 1'b0;
        memBus.MemRData_IN = '0;
        forever begin
            @(posedge CLOCK);
            #2;
            if (memBus.MemReq_OUT === 1'b1) busyCnt++;
            else busyCnt = 0;
            memBus.MemAck_IN   = forceAck || (memBus.MemReq_OUT === 1'b1 && ackDelay != 0 && busyCnt == ackDelay);
            memBus.MemRData_IN = rdataVal;
        end
    end

    // Monitor: accumulates one access and checks it when STALL_OUT drops (DONE).
    int          stallCnt = 0;
    int          reqCnt = 0;
    logic        unstable = 1'b0;
    logic        aborted = 1'b0;
    logic        prevStall = 1'b0;
    logic        seenWe;
    logic [31:0] seenAddr;
    logic [31:0] seenWData;
    logic [5:0]  seenCtrl;

    always @(negedge CLOCK) begin
        exp_t e;
        if (RESET === 1'b1) aborted = 1'b1;
        if (STALL_OUT === 1'b1) stallCnt++;
        if (memBus.MemReq_OUT === 1'b1) begin
            if (reqCnt == 0) begin
                seenWe    = memBus.MemWe_OUT;
                seenAddr  = memBus.MemAddr_OUT;
                seenWData = memBus.MemWData_OUT;
                seenCtrl  = memBus.MemControl_OUT;
                check("flush_in_busy", {31'd0, FLUSH_OUT}, 32'd1);
            end else if (memBus.MemWe_OUT !== seenWe || memBus.MemAddr_OUT !== seenAddr ||
                         memBus.MemWData_OUT !== seenWData || memBus.MemControl_OUT !== seenCtrl) begin
                unstable = 1'b1;
            end
            reqCnt++;
        end
        if (prevStall === 1'b1 && STALL_OUT === 1'b0) begin
            if (aborted) begin
                // access cut short by reset; nothing was expected for it
            end else if (sb.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL unexpected_completion: got access at addr 0x%08h expected none", seenAddr);
            end else begin
                e = sb.pop_front();
                check("read_data", ReadData_OUT, e.readData);
                check("timeout_pulse", {31'd0, Timeout_OUT}, {31'd0, e.timeout});
                check("stall_cycles", stallCnt, e.stall);
                check("req_cycles", reqCnt, e.req);
                check("mem_we", {31'd0, seenWe}, {31'd0, e.we});
                check("mem_addr", seenAddr, e.addr);
                check("mem_wdata", seenWData, e.wdata);
                check("mem_ctrl", {26'd0, seenCtrl}, {26'd0, e.ctrl});
                check("bus_stable", {31'd0, unstable}, 32'd0);
            end
            stallCnt = 0;
            reqCnt   = 0;
            unstable = 1'b0;
        end else if (Timeout_OUT === 1'b1) begin
            nCompared++;
            nMismatched++;
            $display("FAIL stray_timeout: got Timeout_OUT=1 outside DONE expected 0");
        end
        if (STALL_OUT === 1'b0 && RESET === 1'b0) aborted = 1'b0;
        prevStall = STALL_OUT;
    end

    task automatic doAccess(input logic rd, input logic wr, input logic [5:0] ctrl,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ackD, input logic [31:0] rdata,
                            input logic [31:0] expRead, input logic expTo, input logic expWe,
                            input int expStall, input int expReq);
        exp_t e;
        int   n;
        @(posedge CLOCK);
        #1;
        e.readData = expRead;
        e.timeout  = expTo;
        e.stall    = expStall;
        e.req      = expReq;
        e.we       = expWe;
        e.addr     = addr;
        e.wdata    = wdata;
        e.ctrl     = ctrl;
        sb.push_back(e);
        MemRead_IN    = rd;
        MemWrite_IN   = wr;
        MemControl_IN = ctrl;
        Address_IN    = addr;
        WriteData_IN  = wdata;
        ackDelay      = ackD;
        rdataVal      = rdata;
        n = 0;
        do begin
            @(posedge CLOCK);
            #1;
            n++;
        end while (STALL_OUT !== 1'b0 && n < 300);
        if (STALL_OUT !== 1'b0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL access_bound: got STALL_OUT still high after %0d cycles expected DONE", n);
        end
    endtask

    task automatic idle(input int n);
        @(posedge CLOCK);
        #1;
        MemRead_IN    = 1'b0;
        MemWrite_IN   = 1'b0;
        MemControl_IN = '0;
        Address_IN    = '0;
        WriteData_IN  = '0;
        ackDelay      = 0;
        for (int i = 1; i < n; i++) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    initial begin
        RESET = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        check("rst_req", {31'd0, memBus.MemReq_OUT}, 32'd0);
        check("rst_stall", {31'd0, STALL_OUT}, 32'd0);
        check("rst_read_data", ReadData_OUT, 32'd0);
        check("rst_addr", memBus.MemAddr_OUT, 32'd0);
        check("rst_timeout", {31'd0, Timeout_OUT}, 32'd0);

        // Non-memory instruction: address present but no load/store.
        Address_IN = 32'h0000_0999;
        @(negedge CLOCK);
        check("nonmem_stall", {31'd0, STALL_OUT}, 32'd0);
        check("nonmem_flush", {31'd0, FLUSH_OUT}, 32'd0);

        // 1: load acked in first BUSY cycle
        doAccess(1'b1, 1'b0, 6'h02, 32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF,
                 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 1);
        idle(2);
        // 2: store acked after 4 BUSY cycles; read data must not change
        doAccess(1'b0, 1'b1, 6'h05, 32'h0000_0080, 32'h1234_5678, 4, 32'hBAD0_BAD0,
                 32'hDEAD_BEEF, 1'b0, 1'b1, 5, 4);
        idle(2);
        // 3: load never acked, abandoned after 8 BUSY cycles
        doAccess(1'b1, 1'b0, 6'h02, 32'h0000_0100, 32'h0, 0, 32'h7777_7777,
                 32'h0, 1'b1, 1'b0, 9, 8);
        idle(2);
        // 5: read+write together is a write; then back-to-back loads
        doAccess(1'b1, 1'b1, 6'h03, 32'h0000_0044, 32'hCAFE_F00D, 1, 32'h1111_1111,
                 32'h0, 1'b0, 1'b1, 2, 1);
        doAccess(1'b1, 1'b0, 6'h02, 32'h0000_0200, 32'h0, 1, 32'hA5A5_A5A5,
                 32'hA5A5_A5A5, 1'b0, 1'b0, 2, 1);
        doAccess(1'b1, 1'b0, 6'h02, 32'h0000_0204, 32'h0, 2, 32'h5A5A_5A5A,
                 32'h5A5A_5A5A, 1'b0, 1'b0, 3, 2);
        idle(2);

        // 4: reset in the 2nd BUSY cycle of a load, then a late ack
        @(posedge CLOCK);
        #1;
        MemRead_IN = 1'b1;
        Address_IN = 32'h0000_0300;
        ackDelay   = 0;
        rdataVal   = 32'h1357_9BDF;
        @(posedge CLOCK);
        #1;
        @(posedge CLOCK);
        #1;
        RESET      = 1'b1;
        MemRead_IN = 1'b0;
        Address_IN = '0;
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        check("rr_req", {31'd0, memBus.MemReq_OUT}, 32'd0);
        check("rr_stall", {31'd0, STALL_OUT}, 32'd0);
        check("rr_addr", memBus.MemAddr_OUT, 32'd0);
        check("rr_we", {31'd0, memBus.MemWe_OUT}, 32'd0);
        check("rr_ctrl", {26'd0, memBus.MemControl_OUT}, 32'd0);
        check("rr_wdata", memBus.MemWData_OUT, 32'd0);
        check("rr_read_data", ReadData_OUT, 32'd0);
        check("rr_timeout", {31'd0, Timeout_OUT}, 32'd0);
        @(posedge CLOCK);
        #1;
        forceAck = 1'b1;
        @(posedge CLOCK);
        #1;
        forceAck = 1'b0;
        @(negedge CLOCK);
        check("late_ack_read_data", ReadData_OUT, 32'd0);
        check("late_ack_req", {31'd0, memBus.MemReq_OUT}, 32'd0);
        check("late_ack_stall", {31'd0, STALL_OUT}, 32'd0);

        // 6: three loads, each acked after 2 BUSY cycles
        doAccess(1'b1, 1'b0, 6'h02, 32'h0000_0400, 32'h0, 2, 32'h0000_0001,
                 32'h0000_0001, 1'b0, 1'b0, 3, 2);
        doAccess(1'b1, 1'b0, 6'h02, 32'h0000_0404, 32'h0, 2, 32'h0000_0002,
                 32'h0000_0002, 1'b0, 1'b0, 3, 2);
        doAccess(1'b1, 1'b0, 6'h02, 32'h0000_0408, 32'h0, 2, 32'h0000_0003,
                 32'h0000_0003, 1'b0, 1'b0, 3, 2);
        idle(1);
        @(negedge CLOCK);
`ifdef MEM_ACCESS_PERF_EN
        check("perf_access_count", AccessCount_OUT, 32'd3);
        check("perf_stall_cycles", StallCycles_OUT, 32'd9);
`endif

        idle(3);
        @(negedge CLOCK);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
